multicycle_ctrl: RTL and testbench

//  Main control FSM for the multi-cycle RV32I core. Sequences one shared memory port, the ALU and the

---
 rtl/multicycle_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core (shared memory port, ALU, register file).
// Optional feature: define MCTRL_ILLEGAL_TRAP_EN to add the illegal port and a sticky TRAP state.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       imm_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic [1:0]       result_src,
    output logic             reg_write,
    output logic [CNT_W-1:0] retired_cnt
`ifdef MCTRL_ILLEGAL_TRAP_EN
    ,
    output logic             illegal
`endif
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    state_t state, state_nx;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       retire;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7_5    = instr[30];
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // funct3 -> ALU operation; sub only when the caller allows it (R-type)
    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
        logic [2:0] op;
        case (f3)
            3'b000:  op = sub ? 3'b001 : 3'b000;
            3'b010:  op = 3'b101;
            3'b110:  op = 3'b011;
            3'b111:  op = 3'b010;
            default: op = 3'b000;
        endcase
        return op;
    endfunction

    // State register; reset returns to FETCH immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nx;
    end

    // Next-state sequencing
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_R:         state_nx = S_EXECR;
                    OP_IALU:      state_nx = S_EXECI;
                    OP_BEQ:       state_nx = S_BEQ;
                    OP_JAL:       state_nx = S_JAL;
`ifdef MCTRL_ILLEGAL_TRAP_EN
                    default:      state_nx = S_TRAP;
`else
                    default:      state_nx = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_nx = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_nx = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_nx = S_FETCH;
            S_EXECR,
            S_EXECI:  state_nx = S_ALUWB;
            S_MEMWB,
            S_ALUWB,
            S_BEQ,
            S_JAL:    state_nx = S_FETCH;
            S_TRAP:   state_nx = S_TRAP;
            default:  state_nx = S_FETCH;
        endcase
    end

    // An instruction retires on the edge that leaves its final state
    always_comb begin
        retire = 1'b0;
        case (state)
            S_MEMWB, S_ALUWB, S_BEQ, S_JAL: retire = 1'b1;
            S_MEMWR:                        retire = mem_ready;
            default:                        retire = 1'b0;
        endcase
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         retired_cnt <= '0;
        else if (retire) retired_cnt <= retired_cnt + 1'b1;
    end

    // State-decoded outputs; all forced low while reset is asserted
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        imm_src    = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = 3'b000;
        result_src = 2'b00;
        reg_write  = 1'b0;
`ifdef MCTRL_ILLEGAL_TRAP_EN
        illegal    = 1'b0;
`endif
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = 2'b10;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    imm_src   = (opcode == OP_SW) ? 2'b01 : 2'b00;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a = 2'b10;
                    alu_ctrl  = alu_dec(funct3, funct7_5);
                end
                S_EXECI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_ctrl  = alu_dec(funct3, 1'b0);
                end
                S_ALUWB: reg_write = 1'b1;
                S_BEQ: begin
                    alu_src_a = 2'b10;
                    alu_ctrl  = 3'b001;
                    pc_write  = zero;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    imm_src   = 2'b11;
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                end
`ifdef MCTRL_ILLEGAL_TRAP_EN
                S_TRAP: illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues hand-written per-cycle
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  imm_src, alu_src_a, alu_src_b, result_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] retired_cnt;
`ifdef MCTRL_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .result_src(result_src),
        .reg_write(reg_write), .retired_cnt(retired_cnt)
`ifdef MCTRL_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] imm_src;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] alu;
        logic [1:0] res;
        logic       reg_write;
    } ctl_t;

    typedef struct {
        string       name;
        ctl_t        c;
        logic [31:0] cnt;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_cnt;
    ctl_t        act;

    assign act = {mem_req, mem_we, adr_src, ir_write, pc_write, imm_src,
                  alu_src_a, alu_src_b, alu_ctrl, result_src, reg_write};

    ctl_t C_ZERO, C_FWAIT, C_FGO, C_DEC, C_MADR_LW, C_MADR_SW;
    ctl_t C_MRD, C_MWB, C_MWR, C_ALUWB, C_JAL;

    function automatic ctl_t mk(input logic mr, we, as, ir, pw,
                                input logic [1:0] imm, a, b,
                                input logic [2:0] alu,
                                input logic [1:0] res, input logic rw);
        ctl_t c;
        c.mem_req = mr; c.mem_we = we; c.adr_src = as;
        c.ir_write = ir; c.pc_write = pw; c.imm_src = imm;
        c.a = a; c.b = b; c.alu = alu; c.res = res; c.reg_write = rw;
        return c;
    endfunction

    function automatic ctl_t c_execr(input logic [2:0] alu);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 2'b00, 0);
    endfunction

    function automatic ctl_t c_execi(input logic [2:0] alu);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 2'b00, 0);
    endfunction

    function automatic ctl_t c_beq(input logic z);
        return mk(0, 0, 0, 0, z, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0);
    endfunction

    // monitor: compare every queued expectation on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (act !== e.c) begin
                bad++;
                $display("FAIL %s ctl got=%b want=%b", e.name, act, e.c);
            end
            total++;
            if (retired_cnt !== e.cnt) begin
                bad++;
                $display("FAIL %s retired_cnt got=%0d want=%0d",
                         e.name, retired_cnt, e.cnt);
            end
`ifdef MCTRL_ILLEGAL_TRAP_EN
            total++;
            if (illegal !== e.ill) begin
                bad++;
                $display("FAIL %s illegal got=%b want=%b", e.name, illegal, e.ill);
            end
`endif
        end
    end

    task automatic step(input string nm, input logic rdy, input logic z,
                        input ctl_t c, input logic ill, input logic ret);
        exp_t e;
        mem_ready = rdy;
        zero = z;
        e.name = nm; e.c = c; e.cnt = exp_cnt; e.ill = ill;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (ret) exp_cnt = exp_cnt + 1;
    endtask

    task automatic rst_chk(input string nm);
        exp_t e;
        e.name = nm; e.c = C_ZERO; e.cnt = 0; e.ill = 1'b0;
        q.push_back(e);
        @(posedge clk);
        #1;
        exp_cnt = 0;
    endtask

    task automatic fd(input string nm, input logic [31:0] ins);
        instr = ins;
        step({nm, ":fetch"}, 1, 0, C_FGO, 0, 0);
        step({nm, ":decode"}, 1, 0, C_DEC, 0, 0);
    endtask

    task automatic alu_instr(input string nm, input logic [31:0] ins,
                             input ctl_t ex);
        fd(nm, ins);
        step({nm, ":exec"}, 1, 0, ex, 0, 0);
        step({nm, ":aluwb"}, 1, 0, C_ALUWB, 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        rst = 1'b1; instr = 32'h0; zero = 1'b0; mem_ready = 1'b0;
        exp_cnt = 0;
        C_ZERO    = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        C_FWAIT   = mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0);
        C_FGO     = mk(1, 0, 0, 1, 1, 2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0);
        C_DEC     = mk(0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b01, 3'b000, 2'b00, 0);
        C_MADR_LW = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0);
        C_MADR_SW = mk(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b01, 3'b000, 2'b00, 0);
        C_MRD     = mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        C_MWB     = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1);
        C_MWR     = mk(1, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);
        C_ALUWB   = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1);
        C_JAL     = mk(0, 0, 0, 0, 1, 2'b11, 2'b01, 2'b10, 3'b000, 2'b00, 1);

        @(posedge clk);
        #1;
        rst_chk("reset");
        rst = 1'b0;

        // LW x1,4(x0): five cycles, no waits
        fd("lw", 32'h00402083);
        step("lw:memadr", 1, 0, C_MADR_LW, 0, 0);
        step("lw:memrd", 1, 0, C_MRD, 0, 0);
        step("lw:memwb", 1, 0, C_MWB, 0, 1);

        // SW x1,8(x0) with three wait cycles in MEMWR
        fd("sw", 32'h00102423);
        step("sw:memadr", 1, 0, C_MADR_SW, 0, 0);
        for (int i = 0; i < 3; i++) step("sw:memwr_wait", 0, 0, C_MWR, 0, 0);
        step("sw:memwr_done", 1, 0, C_MWR, 0, 1);

        // BEQ taken after two fetch wait cycles, then not taken
        instr = 32'h00208463;
        step("beq:fetch_wait", 0, 0, C_FWAIT, 0, 0);
        step("beq:fetch_wait", 0, 0, C_FWAIT, 0, 0);
        fd("beq_t", 32'h00208463);
        step("beq_t:beq", 1, 1, c_beq(1), 0, 1);
        fd("beq_n", 32'h00208463);
        step("beq_n:beq", 1, 0, c_beq(0), 0, 1);

        // ALU decodes
        alu_instr("sub", 32'h402081B3, c_execr(3'b001));
        alu_instr("slt", 32'h0020A1B3, c_execr(3'b101));
        alu_instr("or", 32'h0020E1B3, c_execr(3'b011));
        alu_instr("sll", 32'h002091B3, c_execr(3'b000));
        alu_instr("addi", 32'h00500093, c_execi(3'b000));
        alu_instr("addi_neg", 32'hC0000093, c_execi(3'b000));
        alu_instr("andi", 32'h00707093, c_execi(3'b010));

        // JAL x1,16
        fd("jal", 32'h010000EF);
        step("jal:jal", 1, 0, C_JAL, 0, 1);

        // unknown opcode
        fd("ill", 32'h0000007F);
`ifdef MCTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) step("ill:trap", 1, 0, C_ZERO, 1, 0);
        rst = 1'b1;
        rst_chk("ill:reset");
        rst = 1'b0;
`endif
        alu_instr("addi_after_ill", 32'h00500093, c_execi(3'b000));

        // reset asserted in the middle of a waiting fetch
        instr = 32'h00500093;
        step("mid:fetch_wait", 0, 0, C_FWAIT, 0, 0);
        mem_ready = 1'b0;
        e.name = "mid:rst_async"; e.c = C_ZERO; e.cnt = 0; e.ill = 1'b0;
        q.push_back(e);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt = 0;
        rst_chk("mid:rst_hold");
        rst = 1'b0;
        alu_instr("addi_post_rst", 32'h00500093, c_execi(3'b000));

        @(posedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
